// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   seg_t          one active-low segment byte: bit 7 dp, bits 6:0 g..a
//   SEG_BLANK      segment byte with every segment off
//   AN_OFF         all-ones anode vector; slice it to the digit count in use
//   DEF_*          default parameter values for the scan controller
package sseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam int AN_MAX = 32;
  localparam logic [AN_MAX-1:0] AN_OFF = '1;

  localparam int DEF_N_DIGITS  = 4;
  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_BLANK_CYC = 1;

endpackage

// File: rtl/sseg_prescaler.sv
// Mod-TICK_DIV refresh prescaler for the scan controller.
//   clk, reset_n   clock, asynchronous active-low reset
//   en             count enable
//   clr            synchronous clear (wins over en)
//   cnt            current position inside the digit slot
//   tick           high on the last cycle of a slot while counting
module sseg_prescaler
  import sseg_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  localparam int CNT_W = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = en && !clr && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode
// seven-segment display fed from a double-buffered frame register.
//
// Parameters: N_DIGITS digits scanned, TICK_DIV cycles per digit slot,
// BLANK_CYC leading blank cycles per slot (only with SSEG_GHOST_BLANK_EN).
//
// Optional feature: define SSEG_GHOST_BLANK_EN to blank an/sseg for the
// first BLANK_CYC cycles of every slot (removes anode/segment skew ghosting).
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             scan enable; low turns every digit off
//   frame_data     byte k = active-low segments of digit k
//   frame_valid    producer offers frame_data
//   frame_ready    pending buffer is empty
//   an             registered active-low digit enables
//   sseg           registered active-low segments
//   frame_done     one-cycle pulse after each completed scan
//
// Handshake: a frame transfers on any rising edge where frame_valid and
// frame_ready are both high. frame_ready depends only on internal state
// (pending buffer empty), never on frame_valid; the producer may hold or
// change frame_data freely while frame_ready is low, it is ignored.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  localparam int IDX_W = $clog2(N_DIGITS),
  localparam int CNT_W = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [8*N_DIGITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_done
);

  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q;
  logic [8*N_DIGITS-1:0] active_q;
  logic [8*N_DIGITS-1:0] pending_q;
  logic                  pend_full_q;

  logic                  wrap;
  logic                  accept;
  logic                  swap;
  logic                  slot_blank;
  logic [N_DIGITS-1:0]   an_d;
  seg_t                  sseg_d;

  // Prescaler is cleared whenever scanning is disabled so a re-enable
  // always starts a fresh slot.
  sseg_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (~en),
    .cnt     (cnt),
    .tick    (tick)
  );

  assign frame_ready = ~pend_full_q;
  assign accept      = frame_valid && !pend_full_q;
  assign wrap        = tick && (idx_q == IDX_W'(N_DIGITS - 1));
  // The active frame only changes at a scan boundary, or at once while the
  // display is dark. Accept needs an empty buffer, swap a full one, so the
  // two never happen on the same edge.
  assign swap        = pend_full_q && (wrap || !en);

`ifdef SSEG_GHOST_BLANK_EN
  assign slot_blank = (cnt < CNT_W'(BLANK_CYC));
`else
  assign slot_blank = 1'b0;
  logic unused_blank;
  assign unused_blank = ^{cnt, 32'(BLANK_CYC)};
`endif

  // Digit index and frame buffers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      active_q    <= '1;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      if (!en) begin
        idx_q <= '0;
      end else if (wrap) begin
        idx_q <= '0;
      end else if (tick) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (accept) begin
        pending_q   <= frame_data;
        pend_full_q <= 1'b1;
      end else if (swap) begin
        active_q    <= pending_q;
        pend_full_q <= 1'b0;
      end
    end
  end

  // Next output values, derived from the current index and active frame.
  always_comb begin
    an_d   = AN_ALL_OFF;
    sseg_d = SEG_BLANK;
    if (en && !slot_blank) begin
      an_d   = ~(N_DIGITS'(1) << idx_q);
      sseg_d = active_q[{idx_q, 3'b000} +: 8];
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= AN_ALL_OFF;
      sseg       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      sseg       <= sseg_d;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

  localparam int ND    = 4;
  localparam int TICK  = 4;
  localparam int BLANK = 1;
  localparam int SCAN  = ND * TICK;
`ifdef SSEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b1;
  logic [8*ND-1:0] frame_data = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [ND-1:0] an;
  logic [7:0]    sseg;
  logic          frame_done;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .N_DIGITS  (ND),
    .TICK_DIV  (TICK),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .an          (an),
    .sseg        (sseg),
    .frame_done  (frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Tracks enabled time since the scan (re)started; digit and slot position
  // follow from plain division, frames move through a one-deep queue.
  int              m_t = 0;
  logic [8*ND-1:0] m_shown = '1;
  logic [8*ND-1:0] exp_q[$];
  logic [ND-1:0]   exp_an = '1;
  logic [7:0]      exp_sseg = 8'hFF;
  logic            exp_done = 1'b0;
  logic            exp_ready = 1'b1;
  int              m_d;
  bit              m_wrap;
  bit              m_full;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t = 0;
      m_shown = '1;
      exp_q.delete();
      exp_an = '1;
      exp_sseg = 8'hFF;
      exp_done = 1'b0;
      exp_ready = 1'b1;
    end else begin
      m_d = (m_t / TICK) % ND;
      if (!en || (GHOST && (m_t % TICK) < BLANK)) begin
        exp_an = '1;
        exp_sseg = 8'hFF;
      end else begin
        exp_an = ~(ND'(1) << m_d);
        exp_sseg = m_shown[8*m_d +: 8];
      end
      m_wrap = en && ((m_t % SCAN) == SCAN - 1);
      exp_done = m_wrap;
      m_full = (exp_q.size() != 0);
      if (m_full && (m_wrap || !en)) m_shown = exp_q.pop_front();
      if (!m_full && frame_valid) exp_q.push_back(frame_data);
      m_t = en ? m_t + 1 : 0;
      exp_ready = (exp_q.size() == 0);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    en = 1'b1;
    frame_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (an !== 4'b1111 || sseg !== 8'hFF || frame_done !== 1'b0 || frame_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_hold t=%0t an=%b sseg=%h done=%b ready=%b required an=1111 sseg=ff done=0 ready=1",
                 $time, an, sseg, frame_done, frame_ready);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2 * SCAN; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL reset_scan t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  task automatic test_load_scan();
    int pulses = 0;
    frame_data = 32'hC0F9A4B0;
    frame_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
      miscompares++;
      $display("FAIL load_accept t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
               $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
    end
    frame_valid = 1'b0;
    for (int i = 0; i < 3 * SCAN; i++) begin
      @(negedge clk);
      vectors++;
      if (i >= SCAN && frame_done === 1'b1) pulses++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL load_scan t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++;
      $display("FAIL done_rate pulses=%0d required 2 in %0d cycles", pulses, 2 * SCAN);
    end
  endtask

  task automatic test_back_pressure();
    int phase = 0;
    frame_data = $urandom;
    frame_valid = 1'b1;
    for (int i = 0; i < 4 * SCAN && phase < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL back_pressure t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
      if (phase == 0 && !exp_ready) begin
        frame_data = $urandom;
        phase = 1;
      end else if (phase == 1 && exp_ready) begin
        phase = 2;
      end else if (phase == 2) begin
        frame_valid = 1'b0;
        phase = 3;
      end
    end
    frame_valid = 1'b0;
    vectors++;
    if (phase != 3) begin
      miscompares++;
      $display("FAIL bp_timeout phase=%0d required 3", phase);
    end
    for (int i = 0; i < 2 * SCAN + 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL bp_show t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  task automatic test_enable_gating();
    bit found = 0;
    for (int i = 0; i < 2 * SCAN && !found; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL en_wait t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
      if (exp_an == 4'b1011) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL en_timeout digit2 not reached");
    end
    en = 1'b0;
    for (int i = 0; i < 2 * SCAN; i++) begin
      @(negedge clk);
      vectors++;
      if (an !== 4'b1111 || sseg !== 8'hFF || frame_done !== 1'b0 || frame_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL en_off t=%0t an=%b sseg=%h done=%b ready=%b required an=1111 sseg=ff done=0 ready=%b",
                 $time, an, sseg, frame_done, frame_ready, exp_ready);
      end
    end
    en = 1'b1;
    for (int i = 0; i < SCAN + 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL en_resume t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    frame_data = $urandom;
    frame_valid = 1'b1;
    for (int i = 0; i < 3 * SCAN && !found; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL ar_wait t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
      if (exp_an == 4'b0111 && !exp_ready) found = 1;
    end
    frame_valid = 1'b0;
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL ar_timeout digit3 with pending frame not reached");
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (an !== 4'b1111 || sseg !== 8'hFF || frame_done !== 1'b0 || frame_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset t=%0t an=%b sseg=%h done=%b ready=%b required an=1111 sseg=ff done=0 ready=1",
               $time, an, sseg, frame_done, frame_ready);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 2 * SCAN; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL ar_after t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, sseg, frame_done, frame_ready} !== {exp_an, exp_sseg, exp_done, exp_ready}) begin
        miscompares++;
        $display("FAIL random t=%0t an=%b/%b sseg=%h/%h done=%b/%b ready=%b/%b (got/required)",
                 $time, an, exp_an, sseg, exp_sseg, frame_done, exp_done, frame_ready, exp_ready);
      end
      en = ($urandom_range(0, 24) != 0);
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_data = $urandom;
    end
    en = 1'b1;
    frame_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_back_pressure();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
